vfb_vin_crop: RTL

VFB_VIN_CROP -- requirements
Module: vfb_vin_crop

---
 rtl/vfb_vin_crop.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vfb_vin_crop.sv
// Crops a raster video stream to a programmable window before the frame buffer input.
// Frames are gated whole: passing starts and stops only at a vertical-sync frame start.
module vfb_vin_crop #(
  parameter int VIDEO_WIDTH = 16,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic                   I_enable,
  input  logic [CNT_WIDTH-1:0]   I_h_start,
  input  logic [CNT_WIDTH-1:0]   I_h_size,
  input  logic [CNT_WIDTH-1:0]   I_v_start,
  input  logic [CNT_WIDTH-1:0]   I_v_size,
  input  logic                   I_vs_n,
  input  logic                   I_de,
  input  logic [VIDEO_WIDTH-1:0] I_data,
  output logic                   O_vs_n,
  output logic                   O_de,
  output logic [VIDEO_WIDTH-1:0] O_data,
  output logic                   O_frame_active,
  output logic [7:0]             O_frame_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_FS, RUN} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state_reg, state_next;
  logic                   vs_prev_reg, de_prev_reg;
  logic [CNT_WIDTH-1:0]   x_reg, x_next, y_reg, y_next;
  logic [CNT_WIDTH-1:0]   h_start_reg, h_size_reg, v_start_reg, v_size_reg;
  logic [CNT_WIDTH-1:0]   h_start_eff, h_size_eff, v_start_eff, v_size_eff;
  logic [CNT_WIDTH-1:0]   x_cur, y_cur;
  logic [CNT_WIDTH:0]     h_end, v_end;
  logic                   fs, eol, in_window, de_next;
  logic [VIDEO_WIDTH-1:0] data_next;
  logic [7:0]             frame_cnt_next;

  assign fs  = ~I_vs_n & vs_prev_reg;
  assign eol = ~I_de & de_prev_reg;

  // On the frame-start cycle itself the new window and a zeroed position already apply,
  // so a pixel coincident with the sync edge is the first pixel of the new frame.
  assign h_start_eff = fs ? I_h_start : h_start_reg;
  assign h_size_eff  = fs ? I_h_size  : h_size_reg;
  assign v_start_eff = fs ? I_v_start : v_start_reg;
  assign v_size_eff  = fs ? I_v_size  : v_size_reg;
  assign x_cur       = fs ? '0 : x_reg;
  assign y_cur       = fs ? '0 : y_reg;

  // One extra bit keeps start+size from wrapping back into the visible range.
  assign h_end = {1'b0, h_start_eff} + {1'b0, h_size_eff};
  assign v_end = {1'b0, v_start_eff} + {1'b0, v_size_eff};

  assign in_window = (x_cur >= h_start_eff) && ({1'b0, x_cur} < h_end) &&
                     (y_cur >= v_start_eff) && ({1'b0, y_cur} < v_end);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (I_enable) state_next = WAIT_FS;
      WAIT_FS: begin
        if (!I_enable)  state_next = IDLE;
        else if (fs)    state_next = RUN;
      end
      RUN:     if (fs && !I_enable) state_next = WAIT_FS;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (fs) begin
      x_next = {{(CNT_WIDTH-1){1'b0}}, I_de};
      y_next = '0;
    end else if (eol) begin
      x_next = '0;
      if (y_reg != CNT_MAX) y_next = y_reg + CNT_ONE;
    end else if (I_de && (x_reg != CNT_MAX)) begin
      x_next = x_reg + CNT_ONE;
    end
  end

  assign de_next        = (state_next == RUN) && I_de && in_window;
  assign frame_cnt_next = (fs && (state_next == RUN)) ? O_frame_cnt + 8'd1 : O_frame_cnt;

  generate
    for (genvar gi = 0; gi < VIDEO_WIDTH; gi++) begin : g_data_mask
      assign data_next[gi] = I_data[gi] & de_next;
    end
  endgenerate

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg   <= IDLE;
      vs_prev_reg <= 1'b1;
      de_prev_reg <= 1'b0;
      x_reg       <= '0;
      y_reg       <= '0;
      h_start_reg <= '0;
      h_size_reg  <= '0;
      v_start_reg <= '0;
      v_size_reg  <= '0;
      O_vs_n      <= 1'b1;
      O_de        <= 1'b0;
      O_data      <= '0;
      O_frame_cnt <= 8'd0;
    end else begin
      state_reg   <= state_next;
      vs_prev_reg <= I_vs_n;
      de_prev_reg <= I_de;
      x_reg       <= x_next;
      y_reg       <= y_next;
      if (fs) begin
        h_start_reg <= I_h_start;
        h_size_reg  <= I_h_size;
        v_start_reg <= I_v_start;
        v_size_reg  <= I_v_size;
      end
      O_vs_n      <= I_vs_n;
      O_de        <= de_next;
      O_data      <= data_next;
      O_frame_cnt <= frame_cnt_next;
    end
  end

  assign O_frame_active = (state_reg == RUN);

endmodule
